// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: PC-1 on start, then one PC-2 subkey per accepted beat, K1..K16 or K16..K1.
// First subkey is valid the cycle after start; under k_ready low, k, k_round and the C/D halves hold.
module des_key_sched_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [0:63] key,
  output logic        busy,
  output logic [0:47] k,
  output logic [3:0]  k_round,
  output logic        k_valid,
  input  logic        k_ready,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Permutation tables hold the FIPS 46-3 entries minus one, so they index bit vectors directly.
  localparam logic [5:0] PC1_IDX [56] = '{
    56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
     9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
    62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
    13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3};

  localparam logic [5:0] PC2_IDX [48] = '{
    13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
    22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
    40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
    43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31};

  function automatic logic [0:55] pc1(input logic [0:63] kin);
    logic [0:55] r;
    for (int i = 0; i < 56; i++) r[i] = kin[PC1_IDX[i]];
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    for (int i = 0; i < 48; i++) r[i] = cd[PC2_IDX[i]];
    return r;
  endfunction

  function automatic logic [0:27] rot_half(input logic [0:27] h, input logic right, input logic two);
    case ({right, two})
      2'b00:   return {h[1:27], h[0]};
      2'b01:   return {h[2:27], h[0:1]};
      2'b10:   return {h[27], h[0:26]};
      default: return {h[26:27], h[0:25]};
    endcase
  endfunction

  // Each half wraps on its own; bits never cross the C/D boundary.
  function automatic logic [0:55] rot_cd(input logic [0:55] cd, input logic right, input logic two);
    return {rot_half(cd[0:27], right, two), rot_half(cd[28:55], right, two)};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic shift_two(input logic [4:0] s);
    return !(s == 5'd1 || s == 5'd2 || s == 5'd9 || s == 5'd16);
  endfunction

  state_t      state_q, state_d;
  logic [0:55] cd_q, cd_d;
  logic [4:0]  j_q, j_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;
  logic [4:0]  shift_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      j_q     <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      j_q     <= j_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Decrypt walks CD16 back to CD1, undoing the shift of the round just issued.
  assign shift_idx = dir_q ? (5'd17 - j_q) : (j_q + 5'd1);

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    j_d     = j_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d   = decrypt;
          cd_d    = decrypt ? pc1(key) : rot_cd(pc1(key), 1'b0, 1'b0);
          j_d     = 5'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (k_ready) begin
          if (j_q == 5'd16) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            j_d  = j_q + 5'd1;
            cd_d = rot_cd(cd_q, dir_q, shift_two(shift_idx));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign k_valid = (state_q == RUN);
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign k       = pc2(cd_q);
  assign k_round = (state_q != RUN) ? 4'd0
                 : dir_q ? (4'd0 - j_q[3:0]) : (j_q[3:0] - 4'd1);

endmodule
